// File: rtl/ofm_drain_reader_if.sv
// ofm_drain_reader_if
//   Bundles the OFM RAM ports and the quantised output stream of the drain reader.
//   master : the drain reader. It drives the RAM read/clear-write requests and the output stream.
//   slave  : the RAM plus the downstream consumer.
//   Signals:
//     ram_rd_en / ram_rd_addr / ram_rd_data  - RAM port A. Data returns 1 cycle after ram_rd_en.
//     ram_wr_en / ram_wr_addr / ram_wr_data  - RAM port B. Clear writes; the data is always 0.
//     out_valid / out_ready / out_data / out_last - int4 activation stream.
interface ofm_drain_reader_if #(
  parameter int unsigned ADDR_BIT = 14
);
  logic                ram_rd_en;
  logic [ADDR_BIT-1:0] ram_rd_addr;
  logic [14:0]         ram_rd_data;
  logic                ram_wr_en;
  logic [ADDR_BIT-1:0] ram_wr_addr;
  logic [14:0]         ram_wr_data;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_data;
  logic                out_last;

  modport master (
    output ram_rd_en, ram_rd_addr,
    input  ram_rd_data,
    output ram_wr_en, ram_wr_addr, ram_wr_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr,
    output ram_rd_data,
    input  ram_wr_en, ram_wr_addr, ram_wr_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/ofm_drain_reader.sv
// ofm_drain_reader
//   Drains the OFM accumulation RAM in address order once a layer finishes.
//   Each 15-bit signed partial sum is processed in three steps:
//     1. ReLU.
//     2. Right shift by SHIFT.
//     3. Saturation to unsigned int4.
//   Results stream out through a 2-entry FIFO. Each location can optionally be
//   zeroed one cycle after it is read.
//   Ports:
//     clk, rst_n   - clock and asynchronous active-low reset.
//     start        - one-cycle pulse that begins a run. Ignored while busy.
//     clear_en     - sampled on an accepted start. 1 = zero each location after it is read.
//     busy         - high from the cycle after an accepted start until done.
//     done         - one-cycle pulse in the cycle after the last element is accepted.
//     bus (master) - RAM ports A/B and the output stream (see ofm_drain_reader_if).
module ofm_drain_reader #(
  parameter int unsigned DEPTH    = 114*114,
  parameter int unsigned ADDR_BIT = 14,
  parameter int unsigned SHIFT    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear_en,
  output logic busy,
  output logic done,
  ofm_drain_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(DEPTH - 1);

  state_t              state;
  logic [ADDR_BIT-1:0] rd_addr;
  logic                clr_q;
  logic                inflight;
  logic                inflight_last;
  logic                wr_en_q;
  logic [ADDR_BIT-1:0] wr_addr_q;

  logic [3:0]          fifo_data [0:1];
  logic                fifo_last [0:1];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_count;

  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occupancy;
  logic [1:0]          count_nxt;
  logic [13:0]         mag;
  logic [3:0]          conv;

  // Issue a read only if, after this cycle's pop, the FIFO still has room for
  // the entries already buffered, the read in flight, and the new read.
  always_comb begin
    pop       = (fifo_count != 2'd0) && bus.out_ready;
    push      = inflight;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    issue     = (state == RUN) && (occupancy < (pop ? 3'd3 : 3'd2));
    count_nxt = fifo_count + {1'b0, push} - {1'b0, pop};
  end

  // ReLU, shift, then saturate to int4.
  always_comb begin
    mag  = bus.ram_rd_data[13:0] >> SHIFT;
    conv = '0;
    if (!bus.ram_rd_data[14]) begin
      conv = (mag > 14'd15) ? 4'hF : mag[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_addr       <= '0;
      clr_q         <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (rd_addr == LAST_ADDR);
      // Clear write trails its read by one cycle, so it never collides with the current read address.
      wr_en_q       <= issue && clr_q;
      if (issue) begin
        wr_addr_q <= rd_addr;
      end

      if (push) begin
        fifo_data[wr_ptr] <= conv;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= count_nxt;

      case (state)
        IDLE: begin
          if (start) begin
            clr_q   <= clear_en;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              // Wrap the counter back to 0 instead of incrementing past DEPTH-1,
              // which may not fit when 2**ADDR_BIT == DEPTH.
              rd_addr <= '0;
              state   <= FLUSH;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Look at the post-pop occupancy so done lands in the cycle after the last handshake.
          if (!inflight && (count_nxt == 2'd0)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ram_rd_en   = issue;
    bus.ram_rd_addr = rd_addr;
    bus.ram_wr_en   = wr_en_q;
    bus.ram_wr_addr = wr_addr_q;
    bus.ram_wr_data = '0;
    bus.out_valid   = (fifo_count != 2'd0);
    bus.out_data    = fifo_data[rd_ptr];
    bus.out_last    = fifo_last[rd_ptr];
  end

endmodule

// File: tb/tb_ofm_drain_reader.sv
// tb_ofm_drain_reader
//   Directed bench for ofm_drain_reader. It uses three instances:
//     A: DEPTH=8, SHIFT=4. Main sequence, backpressure, clear writes, start while busy, mid-run reset.
//     B: DEPTH=3, SHIFT=0. Saturation edge around 15/16.
//     C: DEPTH=1, SHIFT=4. Single-element run.
module tb_ofm_drain_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  ofm_drain_reader_if #(.ADDR_BIT(3)) ifa ();
  logic start_a = 1'b0, clr_a = 1'b0, busy_a, done_a;

  ofm_drain_reader #(.DEPTH(8), .ADDR_BIT(3), .SHIFT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .clear_en(clr_a),
    .busy(busy_a), .done(done_a), .bus(ifa)
  );

  logic [14:0] init_a [0:7] = '{15'd0, 15'd16, 15'd255, 15'd256, 15'h7FFF, 15'h3FFF, 15'd47, 15'h4000};
  int          exp_d  [0:7] = '{0, 1, 15, 15, 0, 15, 2, 0};
  logic [14:0] ram_a [0:7];
  logic [14:0] ram_q_a = '0;
  logic        load_a = 1'b0;

  always @(posedge clk) begin
    if (load_a) begin
      for (int i = 0; i < 8; i++) ram_a[i] <= init_a[i];
    end else if (ifa.ram_wr_en) begin
      ram_a[ifa.ram_wr_addr] <= ifa.ram_wr_data;
    end
    if (ifa.ram_rd_en) ram_q_a <= ram_a[ifa.ram_rd_addr];
  end
  assign ifa.ram_rd_data = ram_q_a;

  // out_ready pattern: mode 0 = always 1, mode 1 = 1,0,0 repeating.
  int   rdy_mode = 0;
  int   rdy_idx = 0;
  logic rdy_a = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) rdy_a = 1'b1;
    else rdy_a = ((rdy_idx % 3) == 0);
    rdy_idx++;
  end
  assign ifa.out_ready = rdy_a;

  // Monitor A (negedge, mid-cycle).
  int   got_d[$], got_l[$], hs_cyc[$];
  int   start_cyc, first_valid_cyc, issued, accepted, max_ahead;
  int   done_cnt, done_cyc, wr_cnt, wr_bad, stab_err;
  logic prev_valid, prev_ready, prev_last, prev_rd_en;
  logic [3:0] prev_data;
  logic [2:0] prev_rd_addr;

  task automatic clear_mon();
    got_d.delete(); got_l.delete(); hs_cyc.delete();
    start_cyc = -100; first_valid_cyc = -1; issued = 0; accepted = 0; max_ahead = 0;
    done_cnt = 0; done_cyc = -1; wr_cnt = 0; wr_bad = 0; stab_err = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_last = 1'b0; prev_data = '0;
    prev_rd_en = 1'b0; prev_rd_addr = '0;
  endtask

  always @(negedge clk) begin
    if (start_a && !busy_a) start_cyc = cyc;
    if (ifa.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_valid && !prev_ready &&
        (!ifa.out_valid || ifa.out_data != prev_data || ifa.out_last != prev_last))
      stab_err++;
    if (ifa.out_valid && ifa.out_ready) begin
      got_d.push_back(int'(ifa.out_data));
      got_l.push_back(int'(ifa.out_last));
      hs_cyc.push_back(cyc);
      accepted++;
    end
    if (ifa.ram_rd_en) issued++;
    if (issued - accepted > max_ahead) max_ahead = issued - accepted;
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ifa.ram_wr_en) begin
      if (!prev_rd_en || ifa.ram_wr_addr != prev_rd_addr ||
          ifa.ram_wr_addr != 3'(wr_cnt) || ifa.ram_wr_data != 15'd0)
        wr_bad++;
      wr_cnt++;
    end
    prev_valid = ifa.out_valid; prev_ready = ifa.out_ready;
    prev_data = ifa.out_data; prev_last = ifa.out_last;
    prev_rd_en = ifa.ram_rd_en; prev_rd_addr = ifa.ram_rd_addr;
  end

  // ---------------- instances B and C ----------------
  ofm_drain_reader_if #(.ADDR_BIT(2)) ifb ();
  ofm_drain_reader_if #(.ADDR_BIT(1)) ifc ();
  logic start_b = 1'b0, start_c = 1'b0, busy_b, busy_c, done_b, done_c;
  logic [14:0] ram_q_b = '0, ram_q_c = '0;

  ofm_drain_reader #(.DEPTH(3), .ADDR_BIT(2), .SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .clear_en(1'b0),
    .busy(busy_b), .done(done_b), .bus(ifb)
  );
  ofm_drain_reader #(.DEPTH(1), .ADDR_BIT(1), .SHIFT(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .clear_en(1'b0),
    .busy(busy_c), .done(done_c), .bus(ifc)
  );

  always @(posedge clk) begin
    if (ifb.ram_rd_en) begin
      case (ifb.ram_rd_addr)
        2'd0: ram_q_b <= 15'd15;
        2'd1: ram_q_b <= 15'd16;
        default: ram_q_b <= 15'd14;
      endcase
    end
    if (ifc.ram_rd_en) ram_q_c <= 15'd80;
  end
  assign ifb.ram_rd_data = ram_q_b;
  assign ifc.ram_rd_data = ram_q_c;
  assign ifb.out_ready = 1'b1;
  assign ifc.out_ready = 1'b1;

  int gb_d[$], gb_l[$], gc_d[$], gc_l[$];
  int done_b_cnt = 0, done_c_cnt = 0;
  always @(negedge clk) begin
    if (ifb.out_valid && ifb.out_ready) begin
      gb_d.push_back(int'(ifb.out_data)); gb_l.push_back(int'(ifb.out_last));
    end
    if (ifc.out_valid && ifc.out_ready) begin
      gc_d.push_back(int'(ifc.out_data)); gc_l.push_back(int'(ifc.out_last));
    end
    if (done_b) done_b_cnt++;
    if (done_c) done_c_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int done_of(input int sel);
    if (sel == 0) return done_cnt;
    if (sel == 1) return done_b_cnt;
    return done_c_cnt;
  endfunction

  task automatic wait_done(input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_of(sel) > 0) break;
    end
  endtask

  task automatic start_run_a(input logic ce);
    start_a = 1'b1; clr_a = ce;
    tick(1);
    start_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic check_seq_a(input string pfx);
    chk({pfx, "_len"}, got_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_d.size()) begin
        chk($sformatf("%s_data%0d", pfx, i), got_d[i], exp_d[i]);
        chk($sformatf("%s_last%0d", pfx, i), got_l[i], (i == 7) ? 1 : 0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_rd_en"},   int'(ifa.ram_rd_en), 0);
    chk({pfx, "_rd_addr"}, int'(ifa.ram_rd_addr), 0);
    chk({pfx, "_wr_en"},   int'(ifa.ram_wr_en), 0);
    chk({pfx, "_wr_addr"}, int'(ifa.ram_wr_addr), 0);
    chk({pfx, "_valid"},   int'(ifa.out_valid), 0);
    chk({pfx, "_data"},    int'(ifa.out_data), 0);
    chk({pfx, "_last"},    int'(ifa.out_last), 0);
    chk({pfx, "_busy"},    int'(busy_a), 0);
    chk({pfx, "_done"},    int'(done_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    clear_mon();
    tick(2);
    check_idle_outputs("rst");
    load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
    rst_n = 1'b1;
    tick(2);

    // 1. Full-rate drain, no clear.
    clear_mon();
    start_run_a(1'b0);
    wait_done(0, 100);
    tick(3);
    chk("t1_done_cnt", done_cnt, 1);
    check_seq_a("t1");
    // start is sampled at the end of its cycle; valid rises two edges later.
    chk("t1_first_valid", first_valid_cyc - start_cyc, 3);
    if (hs_cyc.size() == 8) begin
      chk("t1_tput", hs_cyc[7] - hs_cyc[0], 7);
      chk("t1_done_lat", done_cyc - hs_cyc[7], 1);
    end
    chk("t1_wr_cnt", wr_cnt, 0);
    chk("t1_busy_end", int'(busy_a), 0);

    // 2. Backpressure 1,0,0 with clear writes.
    clear_mon();
    rdy_mode = 1;
    start_run_a(1'b1);
    wait_done(0, 200);
    tick(3);
    rdy_mode = 0;
    chk("t2_done_cnt", done_cnt, 1);
    check_seq_a("t2");
    chk("t2_stable", stab_err, 0);
    chk("t2_ahead", max_ahead, 2);
    if (hs_cyc.size() == 8) chk("t2_done_lat", done_cyc - hs_cyc[7], 1);
    chk("t2_wr_cnt", wr_cnt, 8);
    chk("t2_wr_bad", wr_bad, 0);
    nz = 0;
    for (int i = 0; i < 8; i++) if (ram_a[i] != 15'd0) nz++;
    chk("t2_ram_clear", nz, 0);

    // 3. Extra start pulses while busy are ignored.
    load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
    clear_mon();
    start_run_a(1'b0);
    tick(2);
    start_run_a(1'b1);
    tick(3);
    start_run_a(1'b1);
    wait_done(0, 100);
    tick(10);
    chk("t3_done_cnt", done_cnt, 1);
    check_seq_a("t3");
    chk("t3_wr_cnt", wr_cnt, 0);
    chk("t3_busy_end", int'(busy_a), 0);

    // 4. Reset while element 4 is presented, then a clean rerun.
    clear_mon();
    start_run_a(1'b0);
    for (int i = 0; i < 50; i++) begin
      if (accepted == 3 && ifa.out_valid) break;
      tick(1);
    end
    chk("t4_reach_elem4", accepted, 3);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t4_rst");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_idle", int'(busy_a), 0);
    clear_mon();
    start_run_a(1'b0);
    wait_done(0, 100);
    tick(3);
    chk("t4_done_cnt", done_cnt, 1);
    check_seq_a("t4");

    // 5. SHIFT=0 saturation edge: 15,16,14 -> 15,15,14.
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done(1, 50);
    tick(2);
    chk("b_done_cnt", done_b_cnt, 1);
    chk("b_len", gb_d.size(), 3);
    if (gb_d.size() == 3) begin
      chk("b_d0", gb_d[0], 15); chk("b_d1", gb_d[1], 15); chk("b_d2", gb_d[2], 14);
      chk("b_l0", gb_l[0], 0);  chk("b_l1", gb_l[1], 0);  chk("b_l2", gb_l[2], 1);
    end

    // 6. DEPTH=1: one element, 80>>4 = 5, marked last.
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    wait_done(2, 50);
    tick(2);
    chk("c_done_cnt", done_c_cnt, 1);
    chk("c_len", gc_d.size(), 1);
    if (gc_d.size() == 1) begin
      chk("c_d0", gc_d[0], 5);
      chk("c_l0", gc_l[0], 1);
    end
    chk("c_busy_end", int'(busy_c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_drain_reader.md
Name: ofm_drain_reader

Overview:
- Other end of the OFM accumulation buffer. Once a layer's accumulation into the dual-port OFM RAM is finished, this block reads every location in address order.
- Each 15-bit signed partial sum goes through ReLU, a right shift and saturation to unsigned int4. Results stream out on a valid/ready interface to the next layer's IFM loader.
- Optionally writes zero back to each drained location, so the buffer is clean for the next accumulation pass.

Parameters:
- DEPTH, 114*114, number of OFM locations drained per run.
- ADDR_BIT, 14, RAM address width; requires 2**ADDR_BIT >= DEPTH.
- SHIFT, 4, right-shift applied to the non-negative sum before int4 saturation; legal range 0..14.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous assert, active low; the block uses one clock and this reset only.
- start  in  1  one-cycle pulse that begins a drain run; ignored while busy=1.
- clear_en  in  1  sampled on an accepted start; 1 = zero each location after it is read.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output is accepted.
- ram_rd_en  out  1  RAM port A read enable; data returns 1 cycle later.
- ram_rd_addr  out  ADDR_BIT  RAM port A address.
- ram_rd_data  in  15  RAM port A read data, two's complement.
- ram_wr_en  out  1  RAM port B write enable (clear writes).
- ram_wr_addr  out  ADDR_BIT  RAM port B address.
- ram_wr_data  out  15  always 0.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  4  quantised activation.
- out_last  out  1  qualifies the element from address DEPTH-1.

Behaviour:
- Reset: every output is 0, the FSM is IDLE, the read counter is 0, the 2-entry output FIFO is empty and the in-flight flag is clear. This holds on any cycle, including mid-run; nothing resumes after reset and no done pulse is generated.
- FSM states:
  - IDLE: on start, latch clear_en, set rd_addr=0 and go to RUN.
  - RUN: issue reads. After the read of DEPTH-1 is issued, go to FLUSH.
  - FLUSH: when the FIFO is empty and no read is in flight, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- busy = (state != IDLE).
- Read issue (RUN only): ram_rd_en=1 when fifo_count + inflight + (fifo pop this cycle ? -1 : 0) < 2. This is the credit rule that prevents FIFO overflow under backpressure. rd_addr increments after each issued read.
- Read latency: exactly 1 cycle. inflight is set on issue; on the next cycle the converted data is pushed into the FIFO.
- Clear write: one cycle after each issued read, drive ram_wr_en=1 and ram_wr_addr equal to that read's address, if the latched clear_en=1. The write never targets the address being read in the same cycle.
- Conversion is combinational on ram_rd_data:
  - if bit14=1, result 0;
  - else s = ram_rd_data[13:0] >> SHIFT; result = (s > 15) ? 15 : s[3:0].
- out_last is stored in the FIFO alongside data; it is 1 only for the address DEPTH-1 entry.
- Output: out_valid = FIFO non-empty. out_data and out_last come from the FIFO head and hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop with a full FIFO is legal; count stays the same.
- Throughput: 1 element/cycle sustained when out_ready is held high. First out_valid appears 2 cycles after the start pulse.
- done fires in the cycle after the handshake of the last element.
- DEPTH=1: a single read; its element has out_last=1.

Test Plan:
- DEPTH=8, SHIFT=4, RAM = {0, 16, 255, 256, -1, 0x3FFF, 47, -16384}, out_ready=1 -> out_data = 0, 1, 15, 15, 0, 15, 2, 0; out_last only on the 8th; done 1 cycle after; 1 element per cycle.
- Same data, out_ready toggling 1,0,0,1,... -> identical sequence, no drops or duplicates, out_data stable while stalled, at most 2 reads ahead of the consumer.
- clear_en=1, DEPTH=8 -> 8 writes of 0 to addresses 0..7, each one cycle after its read; RAM all zero after done. With clear_en=0 -> no ram_wr_en at all.
- start pulsed while busy -> ignored; sequence and done count unchanged (exactly one done).
- rst_n asserted during element 4 -> all outputs 0 immediately. A new start afterwards restarts from address 0 with the full 8-element sequence.
- SHIFT=0, data 15 and 16 -> 15, 15; data 14 -> 14.
